// File: rtl/display_scan_if.sv
// display_scan_if: panel-side bundle for the 4-digit scan driver.
// master drives data, load, mask and lz_en; slave returns x, an, busy and frame_tick.
interface display_scan_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [3:0]  x;
  logic [3:0]  an;
  logic        busy;
  logic        frame_tick;

  modport master (
    output value, load, blank_mask, lz_en,
    input  x, an, busy, frame_tick
  );

  modport slave (
    input  value, load, blank_mask, lz_en,
    output x, an, busy, frame_tick
  );
endinterface

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 4-digit 7-seg driver with frame-synchronous
// double-buffered loads, leading-zero suppression and per-digit blanking.
// Ports: clk, rst (sync, active-high); io (slave): value, load, blank_mask, lz_en in;
// x, an (active-low), busy, frame_tick out.
module display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  display_scan_if.slave io
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] pcnt;
  logic [1:0]       idx;
  logic [15:0]      pending;
  logic [15:0]      shadow;
  logic             pend_v;

  logic [3:0] x_q;
  logic [3:0] an_q;
  logic       busy_q;
  logic       ft_q;

  logic       tick;
  logic       bnd;
  logic       sup;
  logic       dark;
  logic [3:0] nib;
  logic [3:0] an_d;
  logic [3:0] x_d;

  assign tick = (pcnt == LAST);
  assign bnd  = tick && (idx == 2'd3);
  assign nib  = shadow[{idx, 2'b00} +: 4];

  // a digit is a leading zero only if it and every digit left of it is zero
  always_comb begin
    sup = 1'b0;
    unique case (1'b1)
      (idx == 2'd3): sup = (shadow[15:12] == 4'h0);
      (idx == 2'd2): sup = (shadow[15:8]  == 8'h00);
      (idx == 2'd1): sup = (shadow[15:4]  == 12'h000);
      (idx == 2'd0): sup = 1'b0;
      default:       sup = 1'b0;
    endcase
  end

  always_comb begin
    dark = io.blank_mask[idx] || (io.lz_en && sup);
    an_d = 4'hF;
    x_d  = 4'h0;
    if (!dark) begin
      an_d = ~(4'b0001 << idx);
      x_d  = nib;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      idx     <= 2'd0;
      pending <= 16'h0000;
      shadow  <= 16'h0000;
      pend_v  <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
      // a load on the boundary itself bypasses pending
      if (bnd) begin
        if (io.load)
          shadow <= io.value;
        else if (pend_v)
          shadow <= pending;
        pend_v <= 1'b0;
      end else if (io.load) begin
        pending <= io.value;
        pend_v  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= 4'h0;
      an_q   <= 4'hF;
      busy_q <= 1'b0;
      ft_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      an_q   <= an_d;
      busy_q <= pend_v;
      ft_q   <= bnd;
    end
  end

  assign io.x          = x_q;
  assign io.an         = an_q;
  assign io.busy       = busy_q;
  assign io.frame_tick = ft_q;

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed driver for the 4-digit 7-segment display of the coffee maker front panel. Holds a 16-bit value (four hex nibbles), steps through the digits at a programmable rate, and presents one nibble at a time on `x` to the downstream binary-to-7-segment decoder while driving the matching active-low digit anode. Loads are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data. Optional leading-zero suppression and per-digit blanking.

## Interface

Parameters:
- `SCAN_DIV`, 50000, clock cycles per digit slot; legal range 2..2^CNT_W.
- `CNT_W`, 16, prescaler width.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  reset, synchronous, active-high.
- `value`  input  16  display data; nibble k drives digit k (digit 0 = rightmost).
- `load`  input  1  single-cycle strobe; captures `value`.
- `blank_mask`  input  4  bit k high forces digit k dark; sampled live, not buffered.
- `lz_en`  input  1  leading-zero suppression enable; sampled live.
- `x`  output  4  nibble to decoder.
- `an`  output  4  digit anodes, active-low, at most one low.
- `busy`  output  1  high while a loaded value awaits commit.
- `frame_tick`  output  1  one-cycle pulse at each frame boundary commit point.

## Operation

- Prescaler `pcnt` counts 0..SCAN_DIV-1, wraps to 0. `tick` = (pcnt == SCAN_DIV-1).
- Digit index `idx` (2 bits) advances on `tick`: 0→1→2→3→0. Frame boundary = `tick` while idx==3.
- Registers: `pending[15:0]`, `shadow[15:0]`, `pend_v`.
- `load` with no frame boundary: pending ← value, pend_v ← 1.
- At frame boundary: if `load` same cycle, shadow ← value (direct commit), pend_v ← 0; else if pend_v, shadow ← pending, pend_v ← 0; else shadow unchanged.
- Repeated `load` before commit: last value wins.
- `busy` = pend_v (registered).
- Suppression: digit k∈{3,2,1} suppressed when lz_en and shadow nibbles k..3 are all zero. Digit 0 never suppressed.
- Digit dark if blank_mask[idx] or suppressed: an = 4'b1111, x = 4'h0.
- Otherwise: an = ~(4'b0001 << idx), x = shadow nibble idx.
- `frame_tick` asserts for the cycle after the frame-boundary cycle.

## Timing

- Reset values: pcnt=0, idx=0, pending=0, shadow=0, pend_v=0; outputs x=4'h0, an=4'b1111, busy=0, frame_tick=0.
- `x`, `an`, `busy`, `frame_tick` are registered: reflect state one cycle after it changes. First cycle after reset release: an=4'b1110, x=4'h0.
- Digit slot length exactly SCAN_DIV cycles; frame = 4·SCAN_DIV cycles.
- Load-to-display latency: from the commit edge, new nibble on `x` one cycle later; worst case from `load` ≈ 4·SCAN_DIV+1 cycles.
- `rst` mid-operation: all state to reset values on the next edge; pending data discarded.
- Changes to `blank_mask`/`lz_en` visible on outputs one cycle later, mid-slot allowed.
- No illegal `an` codes: never more than one bit low, including around wrap and reset.

## Test plan

- Reset: assert rst 3 cycles with load=1, value=16'hFFFF → x=0, an=4'b1111, busy=0; cycle after release an=4'b1110, x=0, shadow unchanged (0).
- Scan (SCAN_DIV=4): load 16'h1234, wait for commit → x sequence 4,3,2,1 with an 1110,1101,1011,0111, each held exactly 4 cycles, frame_tick every 16 cycles.
- Buffering: during a frame showing 16'h1234, load 16'hABCD at idx=1 → remaining digits still 3,2,1; busy=1 until commit; next frame shows D,C,B,A.
- Last-wins and simultaneous: load 16'h1111 then 16'h2222 mid-frame → only 2222 displayed; load 16'h5555 exactly on boundary cycle → 5555 committed, busy stays 0.
- Suppression: lz_en=1, shadow 16'h0070 → digits 3,2 dark (an=1111), digit 1 x=7, digit 0 x=0; shadow 16'h0000 → only digit 0 lit showing 0.
- Blanking: blank_mask=4'b0100 with 16'h1234 → digit 2 slot an=4'b1111, x=0; others normal; toggling mask mid-slot takes effect next cycle.
